// File: rtl/mux_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_arb_if
// Purpose  : Request/grant bundle between the requesters and the round-robin
//            scheduler that drives the shared 8:1 mux select.
// Revision : 1.0 - initial release
// ============================================================================
interface mux_arb_if #(
  parameter int N     = 8,
  parameter int SEL_W = 3
);
  logic [N-1:0]     req;
  logic             done;
  logic [SEL_W-1:0] s;
  logic [N-1:0]     gnt;
  logic             gnt_valid;
  logic             busy;

  // Requester side: raises requests and releases; observes the grant.
  modport master (
    output req, done,
    input  s, gnt, gnt_valid, busy
  );

  // Scheduler side: samples requests and drives the select/grant.
  modport slave (
    input  req, done,
    output s, gnt, gnt_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter
// Purpose  : Round-robin scheduler sharing an 8:1 dataflow mux among 8
//            requesters. Holds a grant until done, withdrawal or (optionally)
//            timeout, then inserts one idle bubble before re-arbitrating.
// Options  : MUX_ARB_TIMEOUT_EN - bound each grant to MAX_HOLD cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
  parameter int N        = 8,
  parameter int SEL_W    = 3,
  parameter int MAX_HOLD = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  mux_arb_if.slave  bus
);

  localparam logic [0:0] c_idle  = 1'b0;
  localparam logic [0:0] c_grant = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] r_s;
  logic [N-1:0]     r_gnt;
  logic             r_gnt_valid;

  logic             w_any_req;
  logic [SEL_W-1:0] w_win;
  logic             w_timeout;
  logic             w_release;

  logic [SEL_W-1:0] w_s_nxt;
  logic [SEL_W-1:0] w_ptr_nxt;
  logic [N-1:0]     w_gnt_nxt;
  logic             w_gnt_valid_nxt;

  assign w_any_req = |bus.req;

  // Rotating priority search: the lowest offset from ptr that is requesting wins.
  always_comb begin
    logic [SEL_W-1:0] v_idx;
    w_win = r_ptr;
    v_idx = r_ptr;
    for (int i = N - 1; i >= 0; i--) begin
      v_idx = r_ptr + SEL_W'(i);
      if (bus.req[v_idx]) begin
        w_win = v_idx;
      end
    end
  end

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [3:0] c_hold_last = 4'(MAX_HOLD - 1);
  logic [3:0] r_hold;

  // Hold counter: counts grant cycles, cleared on release and while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= 4'd0;
    end else if (r_state == c_grant && !w_release) begin
      r_hold <= r_hold + 4'd1;
    end else begin
      r_hold <= 4'd0;
    end
  end

  assign w_timeout = (r_state == c_grant) && (r_hold == c_hold_last);
`else
  assign w_timeout = 1'b0;
`endif

  // Done, withdrawal and timeout all collapse into one release event.
  assign w_release = (r_state == c_grant) &&
                     (bus.done || !bus.req[r_s] || w_timeout);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: arbitrate from IDLE, return to IDLE on release.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (w_any_req) w_state_nxt = c_grant;
      c_grant: if (w_release) w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  // Output logic: next values of the registered select/grant and pointer.
  always_comb begin
    w_s_nxt         = r_s;
    w_ptr_nxt       = r_ptr;
    w_gnt_nxt       = r_gnt;
    w_gnt_valid_nxt = r_gnt_valid;
    case (r_state)
      c_idle: begin
        if (w_any_req) begin
          w_s_nxt         = w_win;
          w_gnt_nxt       = {{(N-1){1'b0}}, 1'b1} << w_win;
          w_gnt_valid_nxt = 1'b1;
        end else begin
          w_gnt_nxt       = '0;
          w_gnt_valid_nxt = 1'b0;
        end
      end
      c_grant: begin
        if (w_release) begin
          w_gnt_nxt       = '0;
          w_gnt_valid_nxt = 1'b0;
          w_ptr_nxt       = r_s + SEL_W'(1);
        end
      end
      default: begin
        w_gnt_nxt       = '0;
        w_gnt_valid_nxt = 1'b0;
      end
    endcase
  end

  // Registered select, grant and priority pointer; reset drops the grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s         <= '0;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
    end else begin
      r_s         <= w_s_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
    end
  end

  assign bus.s         = r_s;
  assign bus.gnt       = r_gnt;
  assign bus.gnt_valid = r_gnt_valid;
  assign bus.busy      = (r_state == c_grant);

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_arbiter
// Purpose  : Self-checking bench for mux_rr_arbiter: directed scenarios plus
//            random traffic compared against a behavioural grant model.
// Options  : MUX_ARB_TIMEOUT_EN - model bounds grants to MAX_HOLD cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

  localparam int c_max_hold = 4;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit c_to_en = 1'b1;
`else
  localparam bit c_to_en = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mux_arb_if bus ();

  mux_rr_arbiter #(.N(8), .SEL_W(3), .MAX_HOLD(c_max_hold)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Model: current owner (-1 = none), last select, priority pointer and
  // number of cycles the current grant has been visible.
  int m_owner;
  int m_s;
  int m_ptr;
  int m_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_s     = 0;
    m_ptr   = 0;
    m_hold  = 0;
  endtask

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".s"},         32'(bus.s),         32'(m_s));
    chk({tag, ".gnt"},       32'(bus.gnt),       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk({tag, ".gnt_valid"}, 32'(bus.gnt_valid), 32'(m_owner >= 0));
    chk({tag, ".busy"},      32'(bus.busy),      32'(m_owner >= 0));
  endtask

  // One clock of stimulus: apply inputs, advance the model at the edge, check.
  task automatic tick(input logic [7:0] r, input logic d, input string tag);
    bit rel;
    bus.req  = r;
    bus.done = d;
    @(posedge clk);
    if (m_owner < 0) begin
      if (r != 8'h00) begin
        m_owner = pick(r, m_ptr);
        m_s     = m_owner;
        m_hold  = 1;
      end
    end else begin
      rel = d || !r[m_owner] || (c_to_en && m_hold >= c_max_hold);
      if (rel) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else begin
        m_hold++;
      end
    end
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    model_reset();
    do_reset();

    // Single request, then done; ptr becomes 3 so bit 3 beats bit 0.
    tick(8'h04, 1'b0, "single_grant");
    chk("single_s", 32'(bus.s), 32'd2);
    tick(8'h04, 1'b1, "single_done");
    tick(8'h00, 1'b1, "idle_done");
    tick(8'h09, 1'b0, "ptr3_grant");
    chk("ptr3_s", 32'(bus.s), 32'd3);
    tick(8'h09, 1'b1, "ptr3_done");

    // Round robin from a fresh pointer: 0..7 then 0, one bubble per grant.
    do_reset();
    for (int g = 0; g < 9; g++) begin
      tick(8'hFF, 1'b0, "rr_grant");
      chk("rr_seq", 32'(bus.s), 32'(g % 8));
      tick(8'hFF, 1'b1, "rr_release");
      chk("rr_bubble", 32'(bus.gnt_valid), 32'd0);
    end

    // Wrap-around: get ptr to 7, then 7 beats 0, then 0 follows.
    tick(8'h40, 1'b0, "wrap_setup");
    tick(8'h40, 1'b1, "wrap_setup_rel");
    tick(8'h81, 1'b0, "wrap_g7");
    chk("wrap_s7", 32'(bus.s), 32'd7);
    tick(8'h81, 1'b1, "wrap_rel7");
    tick(8'h81, 1'b0, "wrap_g0");
    chk("wrap_s0", 32'(bus.s), 32'd0);
    tick(8'h81, 1'b1, "wrap_rel0");

    // Withdrawal: grant 4, extra request does not move s, drop req[4] -> 6.
    tick(8'h10, 1'b0, "wd_g4");
    chk("wd_s4", 32'(bus.s), 32'd4);
    tick(8'h50, 1'b0, "wd_hold");
    tick(8'h40, 1'b0, "wd_drop");
    tick(8'h40, 1'b0, "wd_g6");
    chk("wd_s6", 32'(bus.s), 32'd6);
    tick(8'h00, 1'b0, "wd_rel6");

    // Long hold with done low: bounded only when the timeout is built in.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      tick(8'h03, 1'b0, "hold");
    end
    tick(8'h00, 1'b0, "hold_end");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      r = 8'($urandom) & 8'($urandom);
      tick(r, ($urandom_range(0, 3) == 0), "rand");
    end

    // Asynchronous reset in the middle of a grant to requester 5.
    do_reset();
    tick(8'h20, 1'b0, "rst_g5");
    chk("rst_s5", 32'(bus.s), 32'd5);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick(8'h20, 1'b0, "post_rst_g5");
    tick(8'h00, 1'b0, "post_rst_rel");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
